// File: rtl/pipeline_hazard_unit.sv
// Hazard controller for an N-stage in-order pipeline.
// Turns per-stage stall and redirect requests into pipeline-register
// stall/flush controls, a PC hold and a PC redirect. It also keeps
// saturating performance counters and a front-end deadlock watchdog.
module pipeline_hazard_unit #(
    parameter int NUM_STAGES = 5,
    parameter int ADDR_WIDTH = 32,
    parameter int DELAY_SLOT = 1,
    parameter int CNT_WIDTH  = 32,
    parameter int WDOG_LIMIT = 1024,
    parameter int SEL_WIDTH  = $clog2(NUM_STAGES + 2)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_STAGES-1:0]            stall_req,
    input  logic [NUM_STAGES-1:0]            redirect_valid,
    input  logic [NUM_STAGES*ADDR_WIDTH-1:0] redirect_target,
    output logic                             pc_stall,
    output logic [NUM_STAGES-2:0]            reg_stall,
    output logic [NUM_STAGES-2:0]            reg_flush,
    output logic                             load_pc_we,
    output logic [ADDR_WIDTH-1:0]            load_pc_new,
    input  logic [SEL_WIDTH-1:0]             perf_sel,
    input  logic                             perf_clear,
    output logic [CNT_WIDTH-1:0]             perf_data,
    output logic                             deadlock
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int WD_W  = $clog2(WDOG_LIMIT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WD_W-1:0]      WD_LIM  = WD_W'(WDOG_LIMIT);

    logic [NUM_STAGES-1:0] stall_eff;
    logic [NUM_STAGES-1:0] redir_eff;
    logic [NUM_STAGES-1:0] stage_stall;
    logic [NUM_STAGES-1:0] eligible;
    logic                  win_valid;
    logic [IDX_W-1:0]      win_idx;
    logic [ADDR_WIDTH-1:0] win_target;
    logic                  frozen;

    logic [CNT_WIDTH-1:0]  stall_cnt_reg [NUM_STAGES];
    logic [CNT_WIDTH-1:0]  redirect_cnt_reg;
    logic [CNT_WIDTH-1:0]  perf_data_reg;
    logic [CNT_WIDTH-1:0]  sel_value;
    logic [WD_W-1:0]       wd_cnt_reg;
    logic                  deadlock_reg;

    // Apply the delay-slot defer, build the stall chain and pick the oldest redirect.
    always_comb begin
        stall_eff = stall_req;
        redir_eff = redirect_valid;
        // A stage-1 branch cannot redirect before its delay slot has been
        // fetched. It waits as a stage-1 stall until IF delivers the slot.
        if ((DELAY_SLOT != 0) && redirect_valid[1] && stall_req[0]) begin
            stall_eff[1] = 1'b1;
            redir_eff[1] = 1'b0;
        end
        stage_stall[NUM_STAGES-1] = stall_eff[NUM_STAGES-1];
        for (int s = NUM_STAGES - 2; s >= 0; s--) begin
            stage_stall[s] = stall_eff[s] | stage_stall[s+1];
        end
        // A stalled stage's redirect is ignored; that stage re-asserts it later.
        eligible  = redir_eff & ~stage_stall;
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (eligible[k]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(k);
            end
        end
    end

    assign win_target = redirect_target[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];

    // Per-register control. Registers younger than the winner (less the
    // delay slot) are squashed. A squash beats any stall.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES - 1; gi++) begin : g_reg
            logic squash;
            assign squash        = win_valid && ((gi + DELAY_SLOT) < int'(win_idx));
            assign reg_stall[gi] = ~rst & ~squash & stage_stall[gi+1];
            assign reg_flush[gi] = rst | squash | (stage_stall[gi] & ~stage_stall[gi+1]);
        end
    endgenerate

    assign pc_stall    = rst | (~win_valid & stage_stall[0]);
    assign load_pc_we  = ~rst & win_valid;
    assign load_pc_new = load_pc_we ? win_target : '0;
    assign frozen      = pc_stall & ~load_pc_we;

    // Saturating stall-cause counters, which count raw requests before any defer, and the redirect counter.
    always_ff @(posedge clk) begin
        if (rst || perf_clear) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                stall_cnt_reg[s] <= '0;
            end
            redirect_cnt_reg <= '0;
        end else begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                if (stall_req[s] && (stall_cnt_reg[s] != CNT_MAX)) begin
                    stall_cnt_reg[s] <= stall_cnt_reg[s] + 1'b1;
                end
            end
            if (load_pc_we && (redirect_cnt_reg != CNT_MAX)) begin
                redirect_cnt_reg <= redirect_cnt_reg + 1'b1;
            end
        end
    end

    // Readback mux: stall counters first, then the redirect counter, else zero.
    always_comb begin
        sel_value = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            if (perf_sel == SEL_WIDTH'(s)) begin
                sel_value = stall_cnt_reg[s];
            end
        end
        if (perf_sel == SEL_WIDTH'(NUM_STAGES)) begin
            sel_value = redirect_cnt_reg;
        end
    end

    // Registered readout shows the counter value from before this edge's update.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_data_reg <= '0;
        end else begin
            perf_data_reg <= sel_value;
        end
    end

    // Watchdog: counts consecutive frozen front-end cycles and sets a sticky deadlock flag.
    always_ff @(posedge clk) begin
        if (rst || perf_clear) begin
            wd_cnt_reg   <= '0;
            deadlock_reg <= 1'b0;
        end else if (frozen) begin
            if (wd_cnt_reg != WD_LIM) begin
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end
            if (wd_cnt_reg == WD_LIM - 1'b1) begin
                deadlock_reg <= 1'b1;
            end
        end else begin
            wd_cnt_reg <= '0;
        end
    end

    assign perf_data = perf_data_reg;
    assign deadlock  = deadlock_reg;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit. Two instances share one stimulus:
// A uses the delay slot and an 8-cycle watchdog; B has no delay slot and 4-bit counters.
// Directed steps are followed by random traffic, all checked against a behavioural model.
module tb_pipeline_hazard_unit;

    localparam int N   = 5;
    localparam int AW  = 32;
    localparam int SW  = 3;
    localparam int CWA = 32;
    localparam int CWB = 4;
    localparam int WDA = 8;
    localparam int WDB = 1024;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    stall_req;
    logic [N-1:0]    redirect_valid;
    logic [N*AW-1:0] redirect_target;
    logic [SW-1:0]   perf_sel;
    logic            perf_clear;

    logic            a_pc_stall, a_load_pc_we, a_deadlock;
    logic [N-2:0]    a_reg_stall, a_reg_flush;
    logic [AW-1:0]   a_load_pc_new;
    logic [CWA-1:0]  a_perf_data;
    logic            b_pc_stall, b_load_pc_we, b_deadlock;
    logic [N-2:0]    b_reg_stall, b_reg_flush;
    logic [AW-1:0]   b_load_pc_new;
    logic [CWB-1:0]  b_perf_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_unit #(
        .NUM_STAGES(N), .ADDR_WIDTH(AW), .DELAY_SLOT(1),
        .CNT_WIDTH(CWA), .WDOG_LIMIT(WDA), .SEL_WIDTH(SW)
    ) dut_a (
        .clk(clk), .rst(rst), .stall_req(stall_req), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .pc_stall(a_pc_stall), .reg_stall(a_reg_stall),
        .reg_flush(a_reg_flush), .load_pc_we(a_load_pc_we), .load_pc_new(a_load_pc_new),
        .perf_sel(perf_sel), .perf_clear(perf_clear), .perf_data(a_perf_data),
        .deadlock(a_deadlock)
    );

    pipeline_hazard_unit #(
        .NUM_STAGES(N), .ADDR_WIDTH(AW), .DELAY_SLOT(0),
        .CNT_WIDTH(CWB), .WDOG_LIMIT(WDB), .SEL_WIDTH(SW)
    ) dut_b (
        .clk(clk), .rst(rst), .stall_req(stall_req), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .pc_stall(b_pc_stall), .reg_stall(b_reg_stall),
        .reg_flush(b_reg_flush), .load_pc_we(b_load_pc_we), .load_pc_new(b_load_pc_new),
        .perf_sel(perf_sel), .perf_clear(perf_clear), .perf_data(b_perf_data),
        .deadlock(b_deadlock)
    );

    // Expected values computed by the reference model, indexed [0]=A, [1]=B.
    logic          e_pcs [2];
    logic          e_we  [2];
    logic [N-2:0]  e_rs  [2];
    logic [N-2:0]  e_rf  [2];
    logic [AW-1:0] e_npc [2];
    longint        m_cnt [2][N];
    longint        m_rcnt[2];
    longint        m_pd  [2];
    int            m_wd  [2];
    bit            m_dl  [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Combinational model: a stage is held if it or any later stage stalls.
    // The oldest unheld redirect wins.
    task automatic model_comb(input int d);
        int         ds;
        bit [N-1:0] st;
        bit [N-1:0] rv;
        bit         held [N];
        int         w;
        ds = (d == 0) ? 1 : 0;
        st = stall_req;
        rv = redirect_valid;
        w  = -1;
        if (ds == 1 && rv[1] && st[0]) begin
            st[1] = 1'b1;
            rv[1] = 1'b0;
        end
        for (int s = 0; s < N; s++) begin
            held[s] = 1'b0;
            for (int j = s; j < N; j++) if (st[j]) held[s] = 1'b1;
        end
        for (int k = N - 1; k >= 0; k--) if (w < 0 && rv[k] && !held[k]) w = k;
        if (rst) begin
            e_pcs[d] = 1'b1; e_we[d] = 1'b0; e_rs[d] = '0; e_rf[d] = '1; e_npc[d] = '0;
        end else begin
            e_we[d]  = (w >= 0);
            e_npc[d] = (w >= 0) ? redirect_target[w*AW +: AW] : '0;
            e_pcs[d] = (w >= 0) ? 1'b0 : held[0];
            for (int s = 0; s < N - 1; s++) begin
                if (w >= 0 && s < w - ds) begin
                    e_rs[d][s] = 1'b0;
                    e_rf[d][s] = 1'b1;
                end else begin
                    e_rs[d][s] = held[s+1];
                    e_rf[d][s] = held[s] && !held[s+1];
                end
            end
        end
    endtask

    // Sequential model update for one clock edge, using the inputs present before the edge.
    task automatic model_edge(input int d);
        longint maxv;
        int     lim;
        maxv = (d == 0) ? 64'hFFFF_FFFF : 64'd15;
        lim  = (d == 0) ? WDA : WDB;
        if (rst) begin
            for (int s = 0; s < N; s++) m_cnt[d][s] = 0;
            m_rcnt[d] = 0; m_pd[d] = 0; m_wd[d] = 0; m_dl[d] = 0;
        end else begin
            if (int'(perf_sel) < N)       m_pd[d] = m_cnt[d][perf_sel];
            else if (int'(perf_sel) == N) m_pd[d] = m_rcnt[d];
            else                          m_pd[d] = 0;
            if (perf_clear) begin
                for (int s = 0; s < N; s++) m_cnt[d][s] = 0;
                m_rcnt[d] = 0; m_wd[d] = 0; m_dl[d] = 0;
            end else begin
                for (int s = 0; s < N; s++)
                    if (stall_req[s] && m_cnt[d][s] < maxv) m_cnt[d][s]++;
                if (e_we[d] && m_rcnt[d] < maxv) m_rcnt[d]++;
                if (e_pcs[d] && !e_we[d]) begin
                    if (m_wd[d] < lim) m_wd[d]++;
                    if (m_wd[d] == lim) m_dl[d] = 1'b1;
                end else begin
                    m_wd[d] = 0;
                end
            end
        end
    endtask

    // Wait for the falling edge and check the combinational outputs of both instances.
    task automatic settle();
        @(negedge clk);
        model_comb(0);
        model_comb(1);
        chk("a_pc_stall", a_pc_stall, e_pcs[0]);
        chk("a_reg_stall", a_reg_stall, e_rs[0]);
        chk("a_reg_flush", a_reg_flush, e_rf[0]);
        chk("a_load_pc_we", a_load_pc_we, e_we[0]);
        chk("a_load_pc_new", a_load_pc_new, e_npc[0]);
        chk("b_pc_stall", b_pc_stall, e_pcs[1]);
        chk("b_reg_stall", b_reg_stall, e_rs[1]);
        chk("b_reg_flush", b_reg_flush, e_rf[1]);
        chk("b_load_pc_we", b_load_pc_we, e_we[1]);
        chk("b_load_pc_new", b_load_pc_new, e_npc[1]);
    endtask

    // Advance one clock edge, then check the registered outputs.
    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        chk("a_perf_data", a_perf_data, m_pd[0]);
        chk("a_deadlock", a_deadlock, m_dl[0]);
        chk("b_perf_data", b_perf_data, m_pd[1]);
        chk("b_deadlock", b_deadlock, m_dl[1]);
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    initial begin
        rst = 1'b1; stall_req = '0; redirect_valid = '0; redirect_target = '0;
        perf_sel = '0; perf_clear = 1'b0;

        // Reset state.
        settle();
        chk("rst_pc_stall", a_pc_stall, 1'b1);
        chk("rst_reg_flush", a_reg_flush, 4'b1111);
        chk("rst_reg_stall", a_reg_stall, 4'b0000);
        chk("rst_load_pc_we", a_load_pc_we, 1'b0);
        tick();
        cycle();
        chk("rst_deadlock", a_deadlock, 1'b0);
        chk("rst_perf_data", a_perf_data, 32'd0);
        rst = 1'b0;

        // A stage-1 stall holds the PC and reg0 and bubbles reg1.
        stall_req = 5'b00010;
        settle();
        chk("s1_pc_stall", a_pc_stall, 1'b1);
        chk("s1_reg_stall", a_reg_stall, 4'b0001);
        chk("s1_reg_flush", a_reg_flush, 4'b0010);
        tick();

        // A stage-2 redirect squashes reg0, keeps the delay slot in A, and squashes both in B.
        stall_req = '0; redirect_valid = 5'b00100;
        redirect_target[2*AW +: AW] = 32'h400;
        settle();
        chk("r2_we", a_load_pc_we, 1'b1);
        chk("r2_new", a_load_pc_new, 32'h400);
        chk("r2_flush", a_reg_flush, 4'b0001);
        chk("r2_stall", a_reg_stall, 4'b0000);
        chk("r2_pc_stall", a_pc_stall, 1'b0);
        chk("r2_b_flush", b_reg_flush, 4'b0011);
        tick();

        // Defer: the slot is not yet fetched, so A waits; B has no delay slot and redirects.
        stall_req = 5'b00001; redirect_valid = 5'b00010;
        redirect_target[1*AW +: AW] = 32'h44;
        settle();
        chk("def_we", a_load_pc_we, 1'b0);
        chk("def_pc_stall", a_pc_stall, 1'b1);
        chk("def_stall", a_reg_stall, 4'b0001);
        chk("def_flush", a_reg_flush, 4'b0010);
        chk("nods_we", b_load_pc_we, 1'b1);
        chk("nods_flush", b_reg_flush, 4'b0001);
        tick();
        stall_req = '0;
        settle();
        chk("def_fire_we", a_load_pc_we, 1'b1);
        chk("def_fire_flush", a_reg_flush, 4'b0000);
        tick();

        // The oldest redirect wins. A stall in WB blocks every redirect.
        redirect_valid = 5'b01100;
        redirect_target[2*AW +: AW] = 32'h100;
        redirect_target[3*AW +: AW] = 32'h200;
        settle();
        chk("old_new", a_load_pc_new, 32'h200);
        tick();
        stall_req = 5'b10000;
        settle();
        chk("wb_we", a_load_pc_we, 1'b0);
        chk("wb_stall", a_reg_stall, 4'b1111);
        chk("wb_flush", a_reg_flush, 4'b0000);
        tick();

        // Counters: 10 stage-3 stalls and 3 redirects, then readback.
        stall_req = '0; redirect_valid = '0; perf_clear = 1'b1;
        cycle();
        perf_clear = 1'b0; stall_req = 5'b01000;
        for (int i = 0; i < 10; i++) cycle();
        stall_req = '0; redirect_valid = 5'b00100;
        for (int i = 0; i < 3; i++) cycle();
        redirect_valid = '0; perf_sel = 3'd3;
        cycle();
        chk("cnt_stall3", a_perf_data, 32'd10);
        perf_sel = 3'd5;
        cycle();
        chk("cnt_redirect", a_perf_data, 32'd3);
        perf_sel = 3'd7;
        cycle();
        chk("cnt_unused", a_perf_data, 32'd0);
        perf_clear = 1'b1;
        cycle();
        perf_clear = 1'b0; perf_sel = 3'd3;
        cycle();
        chk("clr_stall3", a_perf_data, 32'd0);
        perf_sel = 3'd5;
        cycle();
        chk("clr_redirect", a_perf_data, 32'd0);

        // Saturation of B's 4-bit counter.
        stall_req = 5'b00001;
        for (int i = 0; i < 20; i++) cycle();
        stall_req = '0; perf_sel = 3'd0;
        cycle();
        chk("sat_b", b_perf_data, 4'hF);
        chk("sat_a", a_perf_data, 32'd20);

        // Watchdog threshold and stickiness.
        perf_clear = 1'b1;
        cycle();
        perf_clear = 1'b0; stall_req = 5'b10000;
        for (int i = 0; i < 7; i++) cycle();
        chk("wd_7", a_deadlock, 1'b0);
        cycle();
        chk("wd_8", a_deadlock, 1'b1);
        stall_req = '0;
        cycle();
        chk("wd_sticky", a_deadlock, 1'b1);
        perf_clear = 1'b1;
        cycle();
        perf_clear = 1'b0;
        chk("wd_cleared", a_deadlock, 1'b0);
        stall_req = 5'b10000;
        for (int i = 0; i < 7; i++) cycle();
        stall_req = '0;
        cycle();
        stall_req = 5'b10000;
        for (int i = 0; i < 7; i++) cycle();
        chk("wd_broken", a_deadlock, 1'b0);

        // Reset in the middle of a count clears everything.
        rst = 1'b1;
        cycle();
        rst = 1'b0; stall_req = '0;
        chk("wd_rst", a_deadlock, 1'b0);
        for (int s = 0; s <= N; s++) begin
            perf_sel = SW'(s);
            cycle();
            chk("rst_cnt", a_perf_data, 32'd0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            for (int s = 0; s < N; s++) begin
                stall_req[s]      = ($urandom_range(0, 3) == 0);
                redirect_valid[s] = ($urandom_range(0, 3) == 0);
                redirect_target[s*AW +: AW] = $urandom();
            end
            perf_sel   = SW'($urandom_range(0, 7));
            perf_clear = ($urandom_range(0, 49) == 0);
            rst        = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
Generalised N-stage hazard controller for the mips_core pipeline.
- Collects per-stage stall requests and per-stage PC-redirect requests.
- Resolves them into per-pipeline-register stall/flush controls, a PC-register stall and a load_pc redirect. Delay-slot semantics are optional.
- Adds saturating per-stage stall-cause counters, a redirect counter with registered readback, and a front-end deadlock watchdog.

Parameters:
NUM_STAGES, 5, pipeline stages; stage 0 = IF, stage NUM_STAGES-1 = oldest (WB side)
ADDR_WIDTH, 32, PC width
DELAY_SLOT, 1, 1 = MIPS branch-delay-slot semantics, 0 = none
CNT_WIDTH, 32, performance counter width
WDOG_LIMIT, 1024, consecutive frozen-front-end cycles before deadlock flag (>=2)
SEL_WIDTH, $clog2(NUM_STAGES+2), perf_sel width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
stall_req  in  NUM_STAGES  stage s cannot advance this cycle (i-cache miss, lw hazard, d-cache miss, ...)
redirect_valid  in  NUM_STAGES  stage k requests a PC redirect
redirect_target  in  NUM_STAGES*ADDR_WIDTH  target for stage k, bits [k*ADDR_WIDTH +: ADDR_WIDTH]
pc_stall  out  1  hold PC register
reg_stall  out  NUM_STAGES-1  hold pipeline register s (between stage s and s+1)
reg_flush  out  NUM_STAGES-1  load bubble into register s
load_pc_we  out  1  overwrite PC
load_pc_new  out  ADDR_WIDTH  new PC
perf_sel  in  SEL_WIDTH  counter select
perf_clear  in  1  synchronous clear of counters and deadlock flag
perf_data  out  CNT_WIDTH  registered counter readout
deadlock  out  1  sticky watchdog flag

Behaviour:
Stage stall chain (combinational):
- stage_stall[N-1] = stall_req[N-1].
- stage_stall[s] = stall_req[s] | stage_stall[s+1].

Delay-slot defer:
- Applies only if DELAY_SLOT=1, redirect_valid[1]=1 and stall_req[0]=1 (slot not yet fetched).
- The stage-1 redirect is suppressed and treated as stall_req[1]=1. The chain is recomputed with it.

Redirect eligibility and winner:
- eff[k] = redirect_valid[k] & ~stage_stall[k], after any defer.
- Winner w = highest k with eff[k]=1, so the oldest redirect wins. A stalled stage's redirect is ignored and the stage re-asserts it.

With a winner:
- load_pc_we=1, load_pc_new=target[w], pc_stall=0.
- Squashed registers: s < w-DELAY_SLOT get reg_flush=1, reg_stall=0. This overrides stage stalls, so a redirect beats an i-cache miss.
- Registers s >= w-DELAY_SLOT use the normal rules.

No winner:
- load_pc_we=0, load_pc_new=0, pc_stall=stage_stall[0].

Normal register rules:
- reg_stall[s] = stage_stall[s+1].
- reg_flush[s] = stage_stall[s] & ~stage_stall[s+1] (bubble).
- Stall has priority: never flush a stalled register except on a squash.

During rst:
- pc_stall=1, reg_stall=0, reg_flush all 1, load_pc_we=0.
- Counters, perf_data and deadlock cleared. Watchdog count = 0.

Counters:
- stall_cnt[s] increments each cycle stall_req[s]=1 (raw input, pre-defer).
- redirect_cnt increments each cycle load_pc_we=1.
- Both saturate at all-ones. perf_clear zeroes them next edge and has priority over increment.

Readback:
- perf_data <= selected counter each clk, so 1-cycle latency. It shows the pre-increment value of that edge.
- perf_sel 0..N-1 selects stall_cnt. perf_sel N selects redirect_cnt. Others read 0.

Watchdog:
- frozen = pc_stall & ~load_pc_we.
- wd_cnt increments while frozen (saturates at WDOG_LIMIT) and resets to 0 on any non-frozen cycle.
- deadlock sets on the edge where wd_cnt reaches WDOG_LIMIT, i.e. asserted after WDOG_LIMIT consecutive frozen cycles.
- Sticky: cleared only by rst or perf_clear. perf_clear also zeroes wd_cnt.

Test Plan:
- Defaults, stall_req=5'b00010 -> pc_stall=1, reg_stall=4'b0001, reg_flush=4'b0010; redirect_valid[2]=1 with target 0x400 in the same cycle -> load_pc_we=1, load_pc_new=0x400, reg_flush=4'b0001 (reg0 squashed; reg1, the delay slot, unflushed since DELAY_SLOT=1), reg_stall=0, pc_stall=0.
- stall_req[0]=1, redirect_valid[1]=1, DELAY_SLOT=1 -> no redirect, pc_stall=1, reg_stall=4'b0001, reg_flush=4'b0010; drop stall_req[0] -> redirect fires, reg_flush=0.
- redirect_valid=5'b01100, targets 0x100 (stage 2) and 0x200 (stage 3) -> load_pc_new=0x200; add stall_req[4]=1 -> no redirect, all reg_stall=1, reg_flush=0.
- DELAY_SLOT=0, redirect_valid[1]=1 -> reg_flush=4'b0001, load_pc_we=1.
- stall_req[3] held 10 cycles, redirect 3 times, then perf_sel=3 -> perf_data=10 one cycle later; perf_sel=5 -> 3; perf_sel=7 -> 0; perf_clear -> both read 0.
- WDOG_LIMIT=8, stall_req[4] held -> deadlock=0 after 7 cycles, 1 after 8 cycles, stays 1 after release; a 7-cycle freeze, one free cycle, then a 7-cycle freeze -> deadlock=0; rst asserted mid-count -> deadlock=0 and all counters read 0.
